// File: rtl/core2axi4l.sv
// rtl/core2axi4l.sv - core req/gnt/rvalid port to single-outstanding AXI4-Lite master bridge
module core2axi4l #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              aclk,
  input  logic              areset,
  // core side
  input  logic              core_req,
  input  logic              core_we,
  input  logic [STRB_W-1:0] core_be,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_err,
  // AXI4-Lite write address
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  // AXI4-Lite write data
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic [STRB_W-1:0] wstrb,
  // AXI4-Lite write response
  input  logic              bvalid,
  output logic              bready,
  input  logic [1:0]        bresp,
  // AXI4-Lite read address
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  // AXI4-Lite read data
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state_q, state_d;

  // Only bit 1 of a response distinguishes error from okay.
  logic unused_resp;
  assign unused_resp = ^{bresp[0], rresp[0]};

  // The response pulse is simply the one-cycle DONE state.
  assign core_rvalid = (state_q == DONE);

  // Next-state decode plus the combinational grant and response readies.
  always_comb begin
    state_d  = state_q;
    core_gnt = 1'b0;
    bready   = 1'b0;
    rready   = 1'b0;
    case (state_q)
      IDLE: begin
        core_gnt = core_req;
        if (core_req) state_d = core_we ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        // Each channel is finished if already handshaken or handshaking now.
        if ((!awvalid || awready) && (!wvalid || wready)) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = DONE;
      end
      RD_REQ: begin
        if (arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        rready = 1'b1;
        if (rvalid) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register, registered AXI request channels and captured response.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      arvalid    <= 1'b0;
      awaddr     <= '0;
      wdata      <= '0;
      wstrb      <= '0;
      araddr     <= '0;
      core_rdata <= '0;
      core_err   <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (core_req) begin
            if (core_we) begin
              awaddr  <= core_addr;
              wdata   <= core_wdata;
              wstrb   <= core_be;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
            end else begin
              araddr  <= core_addr;
              arvalid <= 1'b1;
            end
          end
        end
        WR_REQ: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
        end
        WR_RESP: begin
          if (bvalid) begin
            core_err   <= bresp[1];
            core_rdata <= '0;
          end
        end
        RD_REQ: begin
          if (arready) arvalid <= 1'b0;
        end
        RD_RESP: begin
          if (rvalid) begin
            core_rdata <= rdata;
            core_err   <= rresp[1];
          end
        end
        default: ;
      endcase
    end
  end

  // Protocol checks: valids and payloads hold until accepted.
  a_aw_hold: assert property (@(posedge aclk) disable iff (areset)
    (awvalid && !awready) |=> (awvalid && $stable(awaddr)));
  a_w_hold: assert property (@(posedge aclk) disable iff (areset)
    (wvalid && !wready) |=> (wvalid && $stable(wdata) && $stable(wstrb)));
  a_ar_hold: assert property (@(posedge aclk) disable iff (areset)
    (arvalid && !arready) |=> (arvalid && $stable(araddr)));

  // Reads and writes are never in flight together.
  a_one_outstanding: assert property (@(posedge aclk) disable iff (areset)
    !(arvalid && (awvalid || wvalid)));

  // Core response is a single-cycle pulse.
  a_rvalid_pulse: assert property (@(posedge aclk) disable iff (areset)
    core_rvalid |=> !core_rvalid);

  // A slave response outside its wait state is a protocol violation.
  a_b_in_state: assert property (@(posedge aclk) disable iff (areset)
    bvalid |-> (state_q == WR_RESP));
  a_r_in_state: assert property (@(posedge aclk) disable iff (areset)
    rvalid |-> (state_q == RD_RESP));

endmodule

// File: tb/tb_core2axi4l.sv
// tb/tb_core2axi4l.sv - directed and random self-checking bench for core2axi4l
module tb_core2axi4l;

  logic        aclk = 1'b0;
  logic        areset;
  logic        core_req, core_we;
  logic [3:0]  core_be;
  logic [31:0] core_addr, core_wdata;
  logic        core_gnt, core_rvalid, core_err;
  logic [31:0] core_rdata;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  core2axi4l #(.ADDR_W(32), .DATA_W(32)) dut (
    .aclk(aclk), .areset(areset),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .core_rdata(core_rdata), .core_err(core_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // slave configuration, changed only while the slave is idle
  int         cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  int         aw_hs_cyc = 0, w_hs_cyc = 0;

  logic [31:0] slv_mem [16];
  logic [31:0] ref_mem [16];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AXI4-Lite slave: drives on the falling edge; handshakes flagged at one
  // falling edge take effect at the following rising edge and are applied here
  // on the next falling edge.
  initial begin
    bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
    bit got_aw, got_w, got_ar;
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [31:0] wa, wd, ra;
    logic [3:0]  ws;
    for (int i = 0; i < 16; i++) slv_mem[i] = 32'hDEADBEEF + i * 32'h01010101;
    {awready, wready, bvalid, arready, rvalid} = '0;
    bresp = 2'b00; rresp = 2'b00; rdata = '0;
    {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar} = '0;
    {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
    wa = '0; wd = '0; ra = '0; ws = '0;
    forever begin
      @(negedge aclk);
      if (areset) begin
        {awready, wready, bvalid, arready, rvalid} = '0;
        {aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w, got_ar} = '0;
        {aw_wait, w_wait, b_wait, ar_wait, r_wait} = '0;
      end else begin
        if (aw_hs) begin got_aw = 1; aw_wait = 0; aw_hs_cyc = cyc; end
        if (w_hs)  begin got_w = 1;  w_wait = 0;  w_hs_cyc = cyc;  end
        if (b_hs)  begin bvalid = 0; got_aw = 0; got_w = 0; b_wait = 0; end
        if (ar_hs) begin got_ar = 1; ar_wait = 0; end
        if (r_hs)  begin rvalid = 0; got_ar = 0; r_wait = 0; end
        awready = 0;
        if (awvalid && !got_aw) begin
          if (aw_wait >= cfg_aw) awready = 1; else aw_wait++;
        end
        wready = 0;
        if (wvalid && !got_w) begin
          if (w_wait >= cfg_w) wready = 1; else w_wait++;
        end
        arready = 0;
        if (arvalid && !got_ar) begin
          if (ar_wait >= cfg_ar) arready = 1; else ar_wait++;
        end
        if (got_aw && got_w && !bvalid) begin
          if (b_wait >= cfg_b) begin
            for (int b = 0; b < 4; b++)
              if (ws[b]) slv_mem[wa[5:2]][8*b +: 8] = wd[8*b +: 8];
            bvalid = 1; bresp = cfg_bresp;
          end else b_wait++;
        end
        if (got_ar && !rvalid) begin
          if (r_wait >= cfg_r) begin
            rvalid = 1; rdata = slv_mem[ra[5:2]]; rresp = cfg_rresp;
          end else r_wait++;
        end
        aw_hs = awvalid && awready; if (aw_hs) wa = awaddr;
        w_hs  = wvalid && wready;   if (w_hs) begin wd = wdata; ws = wstrb; end
        b_hs  = bvalid && bready;
        ar_hs = arvalid && arready; if (ar_hs) ra = araddr;
        r_hs  = rvalid && rready;
      end
    end
  end

  // Present a request at a falling edge, wait for grant, check registered request.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, output int gwait);
    core_req = 1; core_we = we; core_addr = addr; core_be = be; core_wdata = wd;
    gwait = 0;
    #1;
    while (!core_gnt && gwait < 50) begin @(negedge aclk); #1; gwait++; end
    chk("gnt_seen", core_gnt, 1);
    @(posedge aclk);
    @(negedge aclk);
    core_req = 0;
    if (we) begin
      chk("awvalid_up", awvalid, 1);
      chk("wvalid_up", wvalid, 1);
      chk("awaddr", awaddr, addr);
      chk("wdata", wdata, wd);
      chk("wstrb", wstrb, be);
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[5:2]][8*b +: 8] = wd[8*b +: 8];
    end else begin
      chk("arvalid_up", arvalid, 1);
      chk("araddr", araddr, addr);
      chk("no_aw_on_read", awvalid, 0);
    end
  endtask

  // Wait for the response pulse (starting in the cycle after grant) and check it.
  task automatic wait_resp(input logic [31:0] exp_rd, input logic exp_err, output int lat);
    lat = 1;
    while (!core_rvalid && lat < 200) begin @(negedge aclk); lat++; end
    chk("resp_seen", core_rvalid, 1);
    chk("core_rdata", core_rdata, exp_rd);
    chk("core_err", core_err, exp_err);
    @(negedge aclk);
    chk("rvalid_pulse", core_rvalid, 0);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic exp_err,
                     output int gwait, output int lat);
    logic [31:0] exp_rd;
    exp_rd = we ? 32'h0 : ref_mem[addr[5:2]];
    issue(we, addr, be, wd, gwait);
    wait_resp(exp_rd, exp_err, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int gw, lat, k;
    bit gnt_seen, rv_seen;
    logic        r_we;
    logic [3:0]  r_idx, r_be;
    logic [31:0] r_wd;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hDEADBEEF + i * 32'h01010101;
    areset = 1; core_req = 0; core_we = 0; core_be = 0; core_addr = 0; core_wdata = 0;
    repeat (3) @(negedge aclk);
    // reset state
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_core_rvalid", core_rvalid, 0);
    chk("rst_core_err", core_err, 0);
    chk("rst_core_rdata", core_rdata, 0);
    chk("rst_bready", bready, 0);
    chk("rst_rready", rready, 0);
    areset = 0;
    @(negedge aclk);

    // zero-wait read of 0x100 (word 0 holds 0xDEADBEEF)
    txn(0, 32'h100, 4'hF, 32'h0, 0, gw, lat);
    chk("rd0_gnt_wait", gw, 0);
    chk("rd0_latency", lat, 3);
    chk("rd0_data_abs", core_rdata, 32'hDEADBEEF);

    // zero-wait write latency
    txn(1, 32'h4, 4'hF, 32'hCAFEF00D, 0, gw, lat);
    chk("wr0_latency", lat, 3);

    // write, awready three cycles before wready
    cfg_w = 3;
    txn(1, 32'h20, 4'h3, 32'h12345678, 0, gw, lat);
    chk("wr_split_latency", lat, 6);
    chk("wr_split_gap", w_hs_cyc - aw_hs_cyc, 3);
    chk("wr_split_mem", slv_mem[8], 32'hE6B55678);
    cfg_w = 0;

    // write SLVERR, then read DECERR returning data anyway
    cfg_bresp = 2'b10;
    txn(1, 32'hC, 4'hF, 32'h0BADF00D, 1, gw, lat);
    cfg_bresp = 2'b00;
    cfg_rresp = 2'b11;
    txn(0, 32'h20, 4'hF, 32'h0, 1, gw, lat);
    chk("decerr_data_abs", core_rdata, 32'hE6B55678);
    cfg_rresp = 2'b01;
    txn(0, 32'hC, 4'hF, 32'h0, 0, gw, lat);
    chk("exokay_data_abs", core_rdata, 32'h0BADF00D);
    cfg_rresp = 2'b00;

    // request held while a slow read is outstanding
    cfg_r = 5;
    issue(0, 32'h4, 4'hF, 32'h0, gw);
    core_req = 1; core_we = 1; core_addr = 32'h8; core_be = 4'hF; core_wdata = 32'h55AA55AA;
    gnt_seen = 0; k = 0;
    forever begin
      #1;
      if (core_gnt) gnt_seen = 1;
      if (core_rvalid || k >= 40) break;
      @(negedge aclk);
      k++;
    end
    chk("busy_no_gnt", gnt_seen, 0);
    chk("busy_resp_seen", core_rvalid, 1);
    chk("busy_rdata", core_rdata, 32'hCAFEF00D);
    @(negedge aclk);
    #1;
    chk("busy_gnt_after_done", core_gnt, 1);
    cfg_r = 0;
    txn(1, 32'h8, 4'hF, 32'h55AA55AA, 0, gw, lat);
    chk("busy_second_gwait", gw, 0);

    // reset while waiting in RD_RESP
    cfg_r = 5;
    issue(0, 32'h10, 4'hF, 32'h0, gw);
    @(negedge aclk);
    areset = 1;
    repeat (2) @(negedge aclk);
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_rready", rready, 0);
    areset = 0;
    rv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge aclk);
      if (core_rvalid) rv_seen = 1;
    end
    chk("rst_mid_no_rvalid", rv_seen, 0);
    cfg_r = 0;
    txn(0, 32'h10, 4'hF, 32'h0, 0, gw, lat);
    chk("rst_mid_idle_gwait", gw, 0);
    chk("rst_mid_next_lat", lat, 3);

    // random mixed traffic against the reference memory
    for (int i = 0; i < 200; i++) begin
      cfg_aw = $urandom_range(0, 7); cfg_w = $urandom_range(0, 7);
      cfg_b  = $urandom_range(0, 7); cfg_ar = $urandom_range(0, 7);
      cfg_r  = $urandom_range(0, 7);
      cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
      r_we  = 1'($urandom_range(0, 1));
      r_idx = 4'($urandom_range(0, 15));
      r_be  = 4'($urandom_range(0, 15));
      r_wd  = $urandom;
      txn(r_we, {26'h0, r_idx, 2'b00}, r_be, r_wd,
          r_we ? cfg_bresp[1] : cfg_rresp[1], gw, lat);
    end
    for (int i = 0; i < 16; i++) chk("final_mem", slv_mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
